// File: rtl/csr_reg.sv
// Machine-mode CSR file for the RV64 pipeline.
// EX and clint write ports, one combinational read port.
module csr_reg #(
  parameter logic [63:0] MISA_VAL    = 64'h8000_0000_0000_1100,
  parameter logic [63:0] MHARTID_VAL = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic [11:0] csr_raddr_i,
  output logic [63:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        clint_we_i,
  input  logic [11:0] clint_addr_i,
  input  logic [63:0] clint_data_i,
  input  logic        tmr_irq_i,
  input  logic        ext_irq_i,
  input  logic        instr_retire_i,
  output logic [63:0] csr_mstatus,
  output logic [63:0] csr_mie,
  output logic [63:0] csr_mtvec,
  output logic [63:0] csr_mepc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [63:0] MSTATUS_RST = 64'h1800;

  // {enable, data}; clint takes priority on an address clash
  function automatic logic [64:0] wr_sel(
    input logic [11:0] a,
    input logic        cwe,
    input logic [11:0] ca,
    input logic [63:0] cd,
    input logic        ewe,
    input logic [11:0] ea,
    input logic [63:0] ed
  );
    if (cwe && ca == a)
      return {1'b1, cd};
    else if (ewe && ea == a)
      return {1'b1, ed};
    else
      return {1'b0, 64'h0};
  endfunction

  logic [64:0] w_mstatus;
  logic [64:0] w_mie;
  logic [64:0] w_mtvec;
  logic [64:0] w_mscratch;
  logic [64:0] w_mepc;
  logic [64:0] w_mcause;
  logic [64:0] w_mcycle;
  logic [64:0] w_minstret;

  assign w_mstatus  = wr_sel(A_MSTATUS, clint_we_i, clint_addr_i,
                        clint_data_i, csr_we_i, csr_waddr_i, csr_wdata_i);
  assign w_mie      = wr_sel(A_MIE, clint_we_i, clint_addr_i,
                        clint_data_i, csr_we_i, csr_waddr_i, csr_wdata_i);
  assign w_mtvec    = wr_sel(A_MTVEC, clint_we_i, clint_addr_i,
                        clint_data_i, csr_we_i, csr_waddr_i, csr_wdata_i);
  assign w_mscratch = wr_sel(A_MSCRATCH, clint_we_i, clint_addr_i,
                        clint_data_i, csr_we_i, csr_waddr_i, csr_wdata_i);
  assign w_mepc     = wr_sel(A_MEPC, clint_we_i, clint_addr_i,
                        clint_data_i, csr_we_i, csr_waddr_i, csr_wdata_i);
  assign w_mcause   = wr_sel(A_MCAUSE, clint_we_i, clint_addr_i,
                        clint_data_i, csr_we_i, csr_waddr_i, csr_wdata_i);
  assign w_mcycle   = wr_sel(A_MCYCLE, clint_we_i, clint_addr_i,
                        clint_data_i, csr_we_i, csr_waddr_i, csr_wdata_i);
  assign w_minstret = wr_sel(A_MINSTRET, clint_we_i, clint_addr_i,
                        clint_data_i, csr_we_i, csr_waddr_i, csr_wdata_i);

  logic [63:0] mstatus_q;
  logic [63:0] mie_q;
  logic [63:0] mtvec_q;
  logic [63:0] mscratch_q;
  logic [63:0] mepc_q;
  logic [63:0] mcause_q;
  logic [63:0] mip_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  // Registers hold already-masked values so reads need no extra logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mip_q      <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (w_mstatus[64])
        mstatus_q <= (w_mstatus[63:0] & 64'h88) | MSTATUS_RST;
      if (w_mie[64])
        mie_q <= w_mie[63:0] & 64'h888;
      if (w_mtvec[64])
        mtvec_q <= w_mtvec[63:0] & ~64'h3;
      if (w_mscratch[64])
        mscratch_q <= w_mscratch[63:0];
      if (w_mepc[64])
        mepc_q <= w_mepc[63:0] & ~64'h1;
      if (w_mcause[64])
        mcause_q <= w_mcause[63:0];
      mip_q <= {52'h0, ext_irq_i, 3'b000, tmr_irq_i, 7'h00};
      if (w_mcycle[64])
        mcycle_q <= w_mcycle[63:0];
      else
        mcycle_q <= mcycle_q + 64'd1;
      if (w_minstret[64])
        minstret_q <= w_minstret[63:0];
      else if (instr_retire_i)
        minstret_q <= minstret_q + 64'd1;
    end
  end

  always_comb begin
    csr_rdata_o   = '0;
    csr_illegal_o = 1'b0;
    unique case (1'b1)
      (csr_raddr_i == A_MSTATUS):  csr_rdata_o = mstatus_q;
      (csr_raddr_i == A_MISA):     csr_rdata_o = MISA_VAL;
      (csr_raddr_i == A_MIE):      csr_rdata_o = mie_q;
      (csr_raddr_i == A_MTVEC):    csr_rdata_o = mtvec_q;
      (csr_raddr_i == A_MSCRATCH): csr_rdata_o = mscratch_q;
      (csr_raddr_i == A_MEPC):     csr_rdata_o = mepc_q;
      (csr_raddr_i == A_MCAUSE):   csr_rdata_o = mcause_q;
      (csr_raddr_i == A_MIP):      csr_rdata_o = mip_q;
      (csr_raddr_i == A_MCYCLE):   csr_rdata_o = mcycle_q;
      (csr_raddr_i == A_MINSTRET): csr_rdata_o = minstret_q;
      (csr_raddr_i == A_MHARTID):  csr_rdata_o = MHARTID_VAL;
      default:                     csr_illegal_o = 1'b1;
    endcase
  end

  assign csr_mstatus = mstatus_q;
  assign csr_mie     = mie_q;
  assign csr_mtvec   = mtvec_q;
  assign csr_mepc    = mepc_q;

endmodule
